// File: rtl/ysyx_210238_trap_ctrl.sv
// Trap sequencer: writes mepc/mcause/mstatus over the clint CSR port, then redirects the PC.
// Optional macro TRAP_MTVEC_VECTORED_EN enables vectored-mode interrupt targets.
module ysyx_210238_trap_ctrl #(
    parameter int XLEN        = 64,
    parameter int ECALL_CAUSE = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_inst_valid,
    input  logic            i_ecall,
    input  logic            i_mret,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_next_pc,
    input  logic            i_cpu_csr_wen,
    input  logic [XLEN-1:0] i_csr_mtvec,
    input  logic [XLEN-1:0] i_csr_mepc,
    input  logic [XLEN-1:0] i_csr_mstatus,
    input  logic            i_global_int_en,
    input  logic            i_mtime_int_en,
    input  logic            i_mtime_int_pend,
    output logic            o_stall,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_clint_csr_wen,
    output logic [11:0]     o_clint_csr_waddr,
    output logic [XLEN-1:0] o_clint_csr_wdata
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        W_MSTATUS,
        W_MRET,
        JUMP
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_epc, r_cause, r_target;
    logic [XLEN-1:0] w_epc_nxt, w_cause_nxt, w_target_nxt;
    logic            w_int_req;
    logic [XLEN-1:0] w_ms_trap, w_ms_mret;
    logic [XLEN-1:0] w_trap_base, w_trap_target;

    assign w_int_req   = i_global_int_en & i_mtime_int_en & i_mtime_int_pend;
    assign w_trap_base = {i_csr_mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_MTVEC_VECTORED_EN
    always_comb begin
        w_trap_target = w_trap_base;
        if (i_csr_mtvec[1:0] == 2'b01 && r_cause[XLEN-1])
            w_trap_target = w_trap_base + XLEN'({r_cause[5:0], 2'b00});
    end
`else
    logic w_unused_mtvec_mode;
    assign w_unused_mtvec_mode = ^i_csr_mtvec[1:0];
    assign w_trap_target       = w_trap_base;
`endif

    always_comb begin
        w_ms_trap        = i_csr_mstatus;
        w_ms_trap[7]     = i_csr_mstatus[3];
        w_ms_trap[3]     = 1'b0;
        w_ms_trap[12:11] = 2'b11;
        w_ms_mret        = i_csr_mstatus;
        w_ms_mret[3]     = i_csr_mstatus[7];
        w_ms_mret[7]     = 1'b1;
        w_ms_mret[12:11] = 2'b11;
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_epc_nxt         = r_epc;
        w_cause_nxt       = r_cause;
        w_target_nxt      = r_target;
        o_stall           = 1'b0;
        o_redirect        = 1'b0;
        o_redirect_pc     = '0;
        o_clint_csr_wen   = 1'b0;
        o_clint_csr_waddr = '0;
        o_clint_csr_wdata = '0;
        case (r_state)
            IDLE: begin
                if (i_inst_valid) begin
                    if (w_int_req) begin
                        o_stall     = 1'b1;
                        w_epc_nxt   = i_next_pc;
                        w_cause_nxt = {1'b1, {(XLEN-4){1'b0}}, 3'd7};
                        w_state_nxt = W_MEPC;
                    end else if (i_ecall) begin
                        o_stall     = 1'b1;
                        w_epc_nxt   = i_pc;
                        w_cause_nxt = XLEN'(ECALL_CAUSE);
                        w_state_nxt = W_MEPC;
                    end else if (i_mret) begin
                        o_stall     = 1'b1;
                        w_state_nxt = W_MRET;
                    end
                end
            end
            W_MEPC: begin
                o_stall           = 1'b1;
                o_clint_csr_wen   = 1'b1;
                o_clint_csr_waddr = ADDR_MEPC;
                o_clint_csr_wdata = r_epc;
                if (!i_cpu_csr_wen) w_state_nxt = W_MCAUSE;
            end
            W_MCAUSE: begin
                o_stall           = 1'b1;
                o_clint_csr_wen   = 1'b1;
                o_clint_csr_waddr = ADDR_MCAUSE;
                o_clint_csr_wdata = r_cause;
                if (!i_cpu_csr_wen) w_state_nxt = W_MSTATUS;
            end
            W_MSTATUS: begin
                o_stall           = 1'b1;
                o_clint_csr_wen   = 1'b1;
                o_clint_csr_waddr = ADDR_MSTATUS;
                o_clint_csr_wdata = w_ms_trap;
                if (!i_cpu_csr_wen) begin
                    w_target_nxt = w_trap_target;
                    w_state_nxt  = JUMP;
                end
            end
            W_MRET: begin
                o_stall           = 1'b1;
                o_clint_csr_wen   = 1'b1;
                o_clint_csr_waddr = ADDR_MSTATUS;
                o_clint_csr_wdata = w_ms_mret;
                if (!i_cpu_csr_wen) begin
                    w_target_nxt = i_csr_mepc;
                    w_state_nxt  = JUMP;
                end
            end
            JUMP: begin
                o_stall       = 1'b1;
                o_redirect    = 1'b1;
                o_redirect_pc = r_target;
                w_state_nxt   = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // Outputs are forced quiet while reset is held so no partial write escapes.
        if (!rst_n) begin
            o_stall           = 1'b0;
            o_redirect        = 1'b0;
            o_redirect_pc     = '0;
            o_clint_csr_wen   = 1'b0;
            o_clint_csr_waddr = '0;
            o_clint_csr_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_epc    <= '0;
            r_cause  <= '0;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_epc    <= w_epc_nxt;
            r_cause  <= w_cause_nxt;
            r_target <= w_target_nxt;
        end
    end

endmodule

// File: tb/tb_ysyx_210238_trap_ctrl.sv
// Bench for ysyx_210238_trap_ctrl: directed test-plan cases plus random traffic against a
// transaction-queue reference model.
module tb_ysyx_210238_trap_ctrl;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_inst_valid, i_ecall, i_mret, i_cpu_csr_wen;
    logic [XLEN-1:0] i_pc, i_next_pc, i_csr_mtvec, i_csr_mepc, i_csr_mstatus;
    logic            i_global_int_en, i_mtime_int_en, i_mtime_int_pend;
    logic            o_stall, o_redirect, o_clint_csr_wen;
    logic [XLEN-1:0] o_redirect_pc, o_clint_csr_wdata;
    logic [11:0]     o_clint_csr_waddr;

    always #5 clk = ~clk;

    ysyx_210238_trap_ctrl #(.XLEN(64), .ECALL_CAUSE(11)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_inst_valid(i_inst_valid), .i_ecall(i_ecall), .i_mret(i_mret),
        .i_pc(i_pc), .i_next_pc(i_next_pc), .i_cpu_csr_wen(i_cpu_csr_wen),
        .i_csr_mtvec(i_csr_mtvec), .i_csr_mepc(i_csr_mepc), .i_csr_mstatus(i_csr_mstatus),
        .i_global_int_en(i_global_int_en), .i_mtime_int_en(i_mtime_int_en),
        .i_mtime_int_pend(i_mtime_int_pend),
        .o_stall(o_stall), .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
        .o_clint_csr_wen(o_clint_csr_wen), .o_clint_csr_waddr(o_clint_csr_waddr),
        .o_clint_csr_wdata(o_clint_csr_wdata)
    );

    // Pending work: kind 0=mepc, 1=mcause, 2=mstatus(trap), 3=mstatus(mret), 4=redirect
    typedef struct {
        int          kind;
        logic [11:0] addr;
        logic [63:0] data;
        logic [63:0] cause;
    } ent_t;
    ent_t q[$];

    int n_assert = 0;
    int n_fail   = 0;

    logic            obs_stall, obs_red, obs_wen;
    logic [63:0]     obs_rpc, obs_data;
    logic [11:0]     obs_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] trap_target(input logic [63:0] mtvec, input logic [63:0] cause);
        logic [63:0] base;
        base = mtvec & ~64'h3;
`ifdef TRAP_MTVEC_VECTORED_EN
        if ((mtvec % 4) == 1 && cause[63]) return base + 4 * (cause % 64);
`endif
        return base;
    endfunction

    function automatic logic [63:0] ms_trap(input logic [63:0] ms);
        return (ms & ~64'h1888) | 64'h1800 | (64'(ms[3]) << 7);
    endfunction

    function automatic logic [63:0] ms_mret(input logic [63:0] ms);
        return (ms & ~64'h1888) | 64'h1880 | (64'(ms[7]) << 3);
    endfunction

    task automatic push_trap(input logic [63:0] epc, input logic [63:0] cause);
        q.push_back('{kind: 0, addr: 12'h341, data: epc,   cause: cause});
        q.push_back('{kind: 1, addr: 12'h342, data: cause, cause: cause});
        q.push_back('{kind: 2, addr: 12'h300, data: 64'd0, cause: cause});
        q.push_back('{kind: 4, addr: 12'h000, data: 64'd0, cause: cause});
    endtask

    // One clock: settle, predict from the model, compare, advance past the edge.
    task automatic step();
        logic        e_stall, e_red, e_wen;
        logic [63:0] e_rpc, e_data;
        logic [11:0] e_addr;
        #1;
        e_stall = 0; e_red = 0; e_wen = 0; e_rpc = 0; e_data = 0; e_addr = 0;
        if (!rst_n) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (i_inst_valid) begin
                if (i_global_int_en && i_mtime_int_en && i_mtime_int_pend) begin
                    e_stall = 1;
                    push_trap(i_next_pc, 64'h8000_0000_0000_0007);
                end else if (i_ecall) begin
                    e_stall = 1;
                    push_trap(i_pc, 64'd11);
                end else if (i_mret) begin
                    e_stall = 1;
                    q.push_back('{kind: 3, addr: 12'h300, data: 64'd0, cause: 64'd0});
                    q.push_back('{kind: 4, addr: 12'h000, data: 64'd0, cause: 64'd0});
                end
            end
        end else begin
            e_stall = 1;
            if (q[0].kind == 4) begin
                e_red = 1;
                e_rpc = q[0].data;
                void'(q.pop_front());
            end else begin
                e_wen  = 1;
                e_addr = q[0].addr;
                case (q[0].kind)
                    2:       e_data = ms_trap(i_csr_mstatus);
                    3:       e_data = ms_mret(i_csr_mstatus);
                    default: e_data = q[0].data;
                endcase
                if (!i_cpu_csr_wen) begin
                    if (q[0].kind == 2) q[1].data = trap_target(i_csr_mtvec, q[1].cause);
                    if (q[0].kind == 3) q[1].data = i_csr_mepc;
                    void'(q.pop_front());
                end
            end
        end
        obs_stall = o_stall; obs_red = o_redirect; obs_rpc = o_redirect_pc;
        obs_wen = o_clint_csr_wen; obs_addr = o_clint_csr_waddr; obs_data = o_clint_csr_wdata;
        chk("stall",       64'(o_stall),           64'(e_stall));
        chk("redirect",    64'(o_redirect),        64'(e_red));
        chk("redirect_pc", o_redirect_pc,          e_rpc);
        chk("wen",         64'(o_clint_csr_wen),   64'(e_wen));
        chk("waddr",       64'(o_clint_csr_waddr), 64'(e_addr));
        chk("wdata",       o_clint_csr_wdata,      e_data);
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        i_inst_valid = 0; i_ecall = 0; i_mret = 0; i_cpu_csr_wen = 0;
        i_global_int_en = 0; i_mtime_int_en = 0; i_mtime_int_pend = 0;
    endtask

    initial begin
        logic [63:0] vec_int_exp;
        rst_n = 0;
        clr();
        i_pc = 0; i_next_pc = 0; i_csr_mtvec = 0; i_csr_mepc = 0; i_csr_mstatus = 0;
        @(posedge clk); #1;
        step();
        chk("reset_stall", 64'(obs_stall), 64'd0);
        chk("reset_wen",   64'(obs_wen),   64'd0);
        step();
        rst_n = 1;
        step();

        // ecall
        i_csr_mtvec = 64'h8000_0400; i_csr_mstatus = 64'h1808; i_csr_mepc = 0;
        i_pc = 64'h8000_0100; i_next_pc = 64'h8000_0104;
        i_inst_valid = 1; i_ecall = 1;
        step(); chk("ecall_T_stall", 64'(obs_stall), 64'd1);
        clr();
        step(); chk("ecall_mepc_addr", 64'(obs_addr), 64'h341); chk("ecall_mepc", obs_data, 64'h8000_0100);
        step(); chk("ecall_mcause", obs_data, 64'hB);
        step(); chk("ecall_mstatus", obs_data, 64'h1880);
        step(); chk("ecall_redir", 64'(obs_red), 64'd1); chk("ecall_redir_pc", obs_rpc, 64'h8000_0400);
        step(); chk("ecall_done_stall", 64'(obs_stall), 64'd0);

        // timer interrupt; valid held high mid-sequence must not retrigger
        i_global_int_en = 1; i_mtime_int_en = 1; i_mtime_int_pend = 1;
        i_next_pc = 64'h8000_0204; i_pc = 64'h8000_0200; i_inst_valid = 1;
        step(); step(); chk("timer_mepc", obs_data, 64'h8000_0204);
        step(); chk("timer_mcause", obs_data, 64'h8000_0000_0000_0007);
        step();
        i_global_int_en = 0;
        step(); chk("timer_redir_pc", obs_rpc, 64'h8000_0400);
        clr(); step();

        // mret
        i_csr_mstatus = 64'h1880; i_csr_mepc = 64'h8000_0204;
        i_inst_valid = 1; i_mret = 1;
        step(); clr();
        step(); chk("mret_mstatus", obs_data, 64'h1888); chk("mret_addr", 64'(obs_addr), 64'h300);
        step(); chk("mret_redir_pc", obs_rpc, 64'h8000_0204);
        step();

        // conflict during W_MCAUSE for two cycles
        i_csr_mstatus = 64'h1808; i_inst_valid = 1; i_ecall = 1;
        step(); clr();
        step();
        i_cpu_csr_wen = 1;
        step(); step(); chk("conflict_hold", obs_data, 64'hB); chk("conflict_hold_wen", 64'(obs_wen), 64'd1);
        i_cpu_csr_wen = 0;
        step(); chk("conflict_retry", obs_data, 64'hB);
        step(); step(); chk("conflict_redir_T6", 64'(obs_red), 64'd1);
        step();

        // priority: interrupt beats ecall
        i_global_int_en = 1; i_mtime_int_en = 1; i_mtime_int_pend = 1;
        i_inst_valid = 1; i_ecall = 1;
        step(); clr();
        step(); step(); chk("prio_cause", obs_data, 64'h8000_0000_0000_0007);
        step(); step(); step();

        // reset in W_MCAUSE
        i_inst_valid = 1; i_ecall = 1;
        step(); clr();
        step();
        rst_n = 0;
        step(); chk("rst_mid_wen", 64'(obs_wen), 64'd0);
        rst_n = 1;
        step(); chk("rst_after_stall", 64'(obs_stall), 64'd0); chk("rst_after_wen", 64'(obs_wen), 64'd0);
        step(); chk("rst_after_wen2", 64'(obs_wen), 64'd0);

        // mtvec mode 01: vectored only when the macro is enabled
`ifdef TRAP_MTVEC_VECTORED_EN
        vec_int_exp = 64'h8000_041C;
`else
        vec_int_exp = 64'h8000_0400;
`endif
        i_csr_mtvec = 64'h8000_0401; i_csr_mstatus = 64'h1808;
        i_global_int_en = 1; i_mtime_int_en = 1; i_mtime_int_pend = 1; i_inst_valid = 1;
        step(); clr();
        step(); step(); step(); step(); chk("vec_timer_pc", obs_rpc, vec_int_exp);
        i_inst_valid = 1; i_ecall = 1;
        step(); clr();
        step(); step(); step(); step(); chk("vec_ecall_pc", obs_rpc, 64'h8000_0400);
        step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n            = ($urandom_range(0, 99) != 0);
            i_inst_valid     = $urandom_range(0, 1);
            i_ecall          = ($urandom_range(0, 3) == 0);
            i_mret           = ($urandom_range(0, 3) == 0);
            i_global_int_en  = ($urandom_range(0, 1) == 0);
            i_mtime_int_en   = ($urandom_range(0, 1) == 0);
            i_mtime_int_pend = ($urandom_range(0, 1) == 0);
            i_cpu_csr_wen    = ($urandom_range(0, 3) == 0);
            i_pc             = {$urandom, $urandom};
            i_next_pc        = {$urandom, $urandom};
            i_csr_mtvec      = {$urandom, $urandom};
            i_csr_mepc       = {$urandom, $urandom};
            i_csr_mstatus    = {$urandom, $urandom};
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
